// File: rtl/de_pkg.sv
// Decode-stage constants and the decoded control bundle shared by the ROM and the queue.
package de_pkg;
   localparam logic [7:0] OP_ADD_RM_R  = 8'h01;
   localparam logic [7:0] OP_ADD_R_RM  = 8'h03;
   localparam logic [7:0] OP_MOV_RM_R  = 8'h89;
   localparam logic [7:0] OP_MOV_R_RM  = 8'h8B;
   localparam logic [7:0] OP_JMP_REL32 = 8'hE9;
   localparam logic [7:0] OP_NOP       = 8'h90;

   localparam logic [1:0] ALU_MOV = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b11;

   localparam logic [2:0] JMP_NONE  = 3'b000;
   localparam logic [2:0] JMP_REL32 = 3'b001;

   localparam int DISP_MAX = 32;

   typedef struct packed {
      logic                re;
      logic                we;
      logic                rmsel;
      logic                ro_needed;
      logic                rm_needed;
      logic                illegal;
      logic [1:0]          alusel;
      logic [2:0]          jmp;
      logic [7:0]          modrm;
      logic [DISP_MAX-1:0] disp;
   } de_bundle_t;
endpackage

// File: rtl/de_decode_rom.sv
// Combinational decode of opcode + ModRM + disp32 into the decode control bundle.
module de_decode_rom
   import de_pkg::*;
(
   input  logic [7:0]          opcode,
   input  logic [7:0]          modrm,
   input  logic [DISP_MAX-1:0] disp,
   output de_bundle_t          bundle
);
   logic mem;
   assign mem = (modrm[7:6] != 2'b11);

   always_comb begin
      bundle = '0;
      case (opcode)
         OP_ADD_RM_R: begin
            bundle.alusel    = ALU_ADD;
            bundle.re        = mem;
            bundle.we        = mem;
            bundle.rmsel     = 1'b1;
            bundle.ro_needed = 1'b1;
            bundle.rm_needed = 1'b1;
            bundle.modrm     = modrm;
            bundle.disp      = disp;
         end
         OP_ADD_R_RM: begin
            bundle.alusel    = ALU_ADD;
            bundle.re        = mem;
            bundle.ro_needed = 1'b1;
            bundle.rm_needed = 1'b1;
            bundle.modrm     = modrm;
            bundle.disp      = disp;
         end
         OP_MOV_RM_R: begin
            bundle.alusel    = ALU_MOV;
            bundle.we        = mem;
            bundle.rmsel     = 1'b1;
            bundle.ro_needed = 1'b1;
            bundle.modrm     = modrm;
            bundle.disp      = disp;
         end
         OP_MOV_R_RM: begin
            bundle.alusel    = ALU_MOV;
            bundle.re        = mem;
            bundle.rm_needed = 1'b1;
            bundle.modrm     = modrm;
            bundle.disp      = disp;
         end
         OP_JMP_REL32: begin
            bundle.jmp  = JMP_REL32;
            bundle.disp = disp;
         end
         OP_NOP:  bundle = '0;
         // Unknown opcodes still occupy a slot so AG sees them in program order.
         default: bundle.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/de_stage_q.sv
// Decode stage: decodes fetch words and buffers them in an in-order queue toward AG.
module de_stage_q
   import de_pkg::*;
#(
   parameter int IW    = 128,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fe_v,
   input  logic [IW-1:0]            instr,
   output logic                     de_ready,
   input  logic                     flush,
   input  logic                     reg_dep,
   input  logic                     mem_dep,
   input  logic                     mr_stall,
   input  logic                     mw_stall,
   output logic                     ag_vin,
   output logic                     ld_ag,
   output logic                     de_re,
   output logic                     de_we,
   output logic                     de_rmsel,
   output logic                     ro_needed,
   output logic                     rm_needed,
   output logic                     de_illegal,
   output logic [1:0]               de_alusel,
   output logic [2:0]               de_jmp,
   output logic [7:0]               de_modrm,
   output logic [DW-1:0]            de_disp,
   output logic [$clog2(DEPTH):0]   de_count
);
   localparam int AW = $clog2(DEPTH);

   de_bundle_t       dec;
   de_bundle_t       head;
   de_bundle_t       store [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             enq;
   logic             deq;
   logic             unused_bits;

   assign unused_bits = ^instr[IW-1:48];

   de_decode_rom u_rom (
      .opcode (instr[7:0]),
      .modrm  (instr[15:8]),
      .disp   (instr[47:16]),
      .bundle (dec)
   );

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign de_ready = !full;
   assign ld_ag    = !(mem_dep | mr_stall | mw_stall);
   assign ag_vin   = !empty && !reg_dep;

   // Flush and reset win over any same-cycle handshake.
   assign enq = fe_v && !full && !flush && !reset;
   assign deq = ag_vin && ld_ag && !flush && !reset;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);
         case ({enq, deq})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) store[wr_ptr] <= dec;
   end

   assign head = empty ? '0 : store[rd_ptr];

   assign de_re      = head.re;
   assign de_we      = head.we;
   assign de_rmsel   = head.rmsel;
   assign ro_needed  = head.ro_needed;
   assign rm_needed  = head.rm_needed;
   assign de_illegal = head.illegal;
   assign de_alusel  = head.alusel;
   assign de_jmp     = head.jmp;
   assign de_modrm   = head.modrm;
   assign de_disp    = head.disp[DW-1:0];
   assign de_count   = count;
endmodule

// File: tb/tb_de_stage_q.sv
// Self-checking bench for de_stage_q: decode table, corner sequences and randomized traffic vs a queue model.
module tb_de_stage_q;
   localparam int IW = 128, DW = 32, DEPTH = 4;

   typedef struct packed {
      logic re, we, rmsel, ro, rm, ill;
      logic [1:0] alu;
      logic [2:0] jmp;
      logic [7:0] modrm;
      logic [31:0] disp;
   } exp_t;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  mb;
      logic [31:0] d;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0, reset = 1'b0, fe_v = 1'b0, flush = 1'b0;
   logic reg_dep = 1'b0, mem_dep = 1'b0, mr_stall = 1'b0, mw_stall = 1'b0;
   logic [IW-1:0] instr = '0;
   logic de_ready, ag_vin, ld_ag, de_re, de_we, de_rmsel, ro_needed, rm_needed, de_illegal;
   logic [1:0] de_alusel;
   logic [2:0] de_jmp;
   logic [7:0] de_modrm;
   logic [DW-1:0] de_disp;
   logic [2:0] de_count;

   int checks = 0, errors = 0;
   exp_t mq[$];
   vec_t tbl[11];

   de_stage_q #(.IW(IW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .fe_v(fe_v), .instr(instr), .de_ready(de_ready),
      .flush(flush), .reg_dep(reg_dep), .mem_dep(mem_dep), .mr_stall(mr_stall),
      .mw_stall(mw_stall), .ag_vin(ag_vin), .ld_ag(ld_ag), .de_re(de_re), .de_we(de_we),
      .de_rmsel(de_rmsel), .ro_needed(ro_needed), .rm_needed(rm_needed),
      .de_illegal(de_illegal), .de_alusel(de_alusel), .de_jmp(de_jmp),
      .de_modrm(de_modrm), .de_disp(de_disp), .de_count(de_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic re, we, rms, ro, rm, ill, input logic [1:0] alu,
                               input logic [2:0] jmp, input logic [7:0] mb, input logic [31:0] d);
      exp_t e;
      e = '{re: re, we: we, rmsel: rms, ro: ro, rm: rm, ill: ill, alu: alu, jmp: jmp, modrm: mb, disp: d};
      return e;
   endfunction

   // Reference decode: one row per opcode rule, memory form when mod != 3.
   function automatic exp_t model_dec(input logic [IW-1:0] w);
      logic m;
      m = (w[15:14] != 2'b11);
      case (w[7:0])
         8'h01: return mk(m, m, 1, 1, 1, 0, 2'b11, 0, w[15:8], w[47:16]);
         8'h03: return mk(m, 0, 0, 1, 1, 0, 2'b11, 0, w[15:8], w[47:16]);
         8'h89: return mk(0, m, 1, 1, 0, 0, 2'b00, 0, w[15:8], w[47:16]);
         8'h8B: return mk(m, 0, 0, 0, 1, 0, 2'b00, 0, w[15:8], w[47:16]);
         8'hE9: return mk(0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 8'h00, w[47:16]);
         8'h90: return '0;
         default: return mk(0, 0, 0, 0, 0, 1, 2'b00, 0, 8'h00, 32'h0);
      endcase
   endfunction

   function automatic logic [IW-1:0] mkw(input logic [7:0] op, mb, input logic [31:0] d);
      logic [IW-1:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      w[7:0] = op;
      w[15:8] = mb;
      w[47:16] = d;
      return w;
   endfunction

   function automatic exp_t got_b();
      return {de_re, de_we, de_rmsel, ro_needed, rm_needed, de_illegal,
              de_alusel, de_jmp, de_modrm, de_disp};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
      end
   endtask

   // One cycle: drive at negedge, compare against model, advance model at posedge.
   task automatic step(input logic v, input logic [IW-1:0] w, input logic fl, rd, md, mrs, mws);
      exp_t hd;
      logic ldm, enq, deq;
      @(negedge clk);
      fe_v = v; instr = w; flush = fl; reg_dep = rd;
      mem_dep = md; mr_stall = mrs; mw_stall = mws;
      #1;
      hd  = (mq.size() > 0) ? mq[0] : '0;
      ldm = !(md | mrs | mws);
      chk("cycle", {ag_vin, ld_ag, de_ready, de_count, got_b()},
          {(mq.size() > 0) && !rd, ldm, mq.size() < DEPTH, 3'(mq.size()), hd});
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         enq = v && (mq.size() < DEPTH);
         deq = (mq.size() > 0) && !rd && ldm;
         if (deq) void'(mq.pop_front());
         if (enq) mq.push_back(model_dec(w));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; fe_v = 1'b0; flush = 1'b0; reg_dep = 1'b0;
      mem_dep = 1'b0; mr_stall = 1'b0; mw_stall = 1'b0;
      @(posedge clk);
      mq.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset", {ag_vin, de_ready, de_count, got_b()}, {1'b0, 1'b1, 3'd0, 51'd0});
   endtask

   initial begin
      tbl[0]  = '{8'h01, 8'hC1, 32'h0,        mk(0,0,1,1,1,0,2'b11,0,8'hC1,32'h0)};
      tbl[1]  = '{8'h01, 8'h05, 32'h00001000, mk(1,1,1,1,1,0,2'b11,0,8'h05,32'h00001000)};
      tbl[2]  = '{8'h03, 8'h45, 32'h12345678, mk(1,0,0,1,1,0,2'b11,0,8'h45,32'h12345678)};
      tbl[3]  = '{8'h03, 8'hD8, 32'h000000AA, mk(0,0,0,1,1,0,2'b11,0,8'hD8,32'h000000AA)};
      tbl[4]  = '{8'h89, 8'h00, 32'h00000004, mk(0,1,1,1,0,0,2'b00,0,8'h00,32'h00000004)};
      tbl[5]  = '{8'h89, 8'hC3, 32'h00000000, mk(0,0,1,1,0,0,2'b00,0,8'hC3,32'h0)};
      tbl[6]  = '{8'h8B, 8'h80, 32'hDEADBEEF, mk(1,0,0,0,1,0,2'b00,0,8'h80,32'hDEADBEEF)};
      tbl[7]  = '{8'hE9, 8'h77, 32'h00000100, mk(0,0,0,0,0,0,2'b00,3'b001,8'h00,32'h00000100)};
      tbl[8]  = '{8'h90, 8'h55, 32'h0000FFFF, mk(0,0,0,0,0,0,2'b00,0,8'h00,32'h0)};
      tbl[9]  = '{8'h0F, 8'h12, 32'h00000034, mk(0,0,0,0,0,1,2'b00,0,8'h00,32'h0)};
      tbl[10] = '{8'hFF, 8'hC0, 32'h00000099, mk(0,0,0,0,0,1,2'b00,0,8'h00,32'h0)};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // Decode table: enqueue under a read stall, inspect head, then drain.
      foreach (tbl[i]) begin
         step(1, mkw(tbl[i].op, tbl[i].mb, tbl[i].d), 0, 0, 0, 1, 0);
         #2;
         chk($sformatf("dec%0d", i), {ag_vin, de_count, got_b()}, {1'b1, 3'd1, tbl[i].e});
         step(0, '0, 0, 0, 0, 0, 0);
      end

      // Fill past capacity under stall; fifth is refused, then drain in order.
      for (int i = 0; i < 5; i++) step(1, mkw(8'h01, 8'(i), 32'(i + 1)), 0, 0, 0, 1, 0);
      #2;
      chk("full_count", {de_count, de_ready}, {3'd4, 1'b0});
      for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 0, 0, 0);

      // Head held by reg_dep, released in the same cycle it drops.
      step(1, mkw(8'h03, 8'h06, 32'h55), 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0, 0);

      // Illegal opcode sits in order between neighbours.
      step(1, mkw(8'h89, 8'h04, 32'h10), 0, 0, 0, 0, 1);
      step(1, mkw(8'h0F, 8'h04, 32'h20), 0, 0, 0, 0, 1);
      step(1, mkw(8'h8B, 8'h04, 32'h30), 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, 0);

      // Flush with three queued and a concurrent fetch.
      for (int i = 0; i < 3; i++) step(1, mkw(8'h01, 8'h00, 32'(i)), 0, 0, 1, 0, 0);
      step(1, mkw(8'h03, 8'h00, 32'h9), 1, 0, 0, 0, 0);
      #2;
      chk("flush", {de_count, ag_vin, got_b()}, {3'd0, 1'b0, 51'd0});

      // Randomized traffic with occasional mid-stream reset.
      for (int n = 0; n < 600; n++) begin
         logic [7:0] op;
         case ($urandom_range(0, 6))
            0: op = 8'h01; 1: op = 8'h03; 2: op = 8'h89; 3: op = 8'h8B;
            4: op = 8'hE9; 5: op = 8'h90; default: op = 8'($urandom);
         endcase
         if ($urandom_range(0, 99) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, mkw(op, 8'($urandom), $urandom),
                   $urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                   $urandom_range(0, 8) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/de_stage_q.md
# de_stage_q

Parametrised decode stage for the x86 pipeline: accepts raw instruction words from fetch, decodes a fixed opcode subset into the decode control bundle, and buffers decoded entries in a DEPTH-entry in-order queue feeding address generation (AG). Replaces the single-instruction, stall-agnostic decode with real enqueue/dequeue handshakes, register-dependency hold, memory-stall backpressure, flush and illegal-opcode flagging.

## Interface
- IW, 128: instruction word width from fetch; must be ≥ 48.
- DW, 32: displacement width.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- fe_v  in  1  fetch presents a valid instruction.
- instr  in  IW  instruction: [7:0] opcode, [15:8] ModRM, [47:16] disp32 (low DW bits used), upper bits ignored.
- de_ready  out  1  queue can accept; equals !full (registered count only).
- flush  in  1  discard all queued entries (branch redirect).
- reg_dep, mem_dep, mr_stall, mw_stall  in  1 each  hazard/stall inputs from downstream.
- ag_vin  out  1  head entry valid toward AG.
- ld_ag  out  1  AG may load this cycle.
- de_re, de_we, de_rmsel, ro_needed, rm_needed, de_illegal  out  1 each  head-entry control bits.
- de_alusel  out  2  ALU select; de_jmp  out  3  jump kind; de_modrm  out  8; de_disp  out  DW.
- de_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Decode (combinational, before enqueue), mod = modrm[7:6], mem = (mod != 2'b11):
  - 0x01 ADD r/m,r: alusel=11, re=mem, we=mem, rmsel=1, ro_needed=1, rm_needed=1.
  - 0x03 ADD r,r/m: alusel=11, re=mem, we=0, rmsel=0, ro=1, rm=1.
  - 0x89 MOV r/m,r: alusel=00, re=0, we=mem, rmsel=1, ro=1, rm=0.
  - 0x8B MOV r,r/m: alusel=00, re=mem, we=0, rmsel=0, ro=0, rm=1.
  - 0xE9 JMP rel32: jmp=3'b001, disp=instr[47:16], modrm=0, all else 0.
  - 0x90 NOP: all fields 0.
  - any other opcode: all fields 0, de_illegal=1 (entry still enqueued, in order).
  - ModRM opcodes carry modrm=instr[15:8] and disp=instr[47:16]; jmp=000 unless JMP.
- Enqueue: fe_v && de_ready at edge → decoded bundle written at tail.
- ld_ag = !(mem_dep | mr_stall | mw_stall) (combinational).
- ag_vin = !empty && !reg_dep (combinational).
- Dequeue: ag_vin && ld_ag at edge → head popped.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; legal only when not full (de_ready gates enqueue).
- Outputs show head entry; when empty all bundle outputs are 0.
- Flush: next edge clears count and pointers; overrides same-cycle enqueue and dequeue.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: de_count=0, ag_vin=0, de_ready=1, all bundle outputs 0; ld_ag purely combinational from inputs.
- Latency: instruction accepted at edge N is at head, ag_vin=1 (no reg_dep), in cycle N+1 when queue was empty.
- de_ready falls the cycle after the DEPTH-th entry is held; no combinational fe→de_ready path.
- reg_dep or any stall holds the head unchanged; outputs stable while held.
- Reset mid-operation: behaves as flush plus output clear on the same edge.

## Structure
- Package de_pkg: opcode constants (OP_ADD_RM_R, OP_ADD_R_RM, OP_MOV_RM_R, OP_MOV_R_RM, OP_JMP_REL32, OP_NOP), alusel encodings, jmp encodings, packed decode-bundle typedef.
- Sub-module de_decode_rom: combinational opcode+ModRM+disp → bundle.
- Top de_stage_q: queue storage, pointers, count, handshake logic.

## Test plan
- Reset, then fe_v=1 instr opcode 0x01 ModRM 0xC1 → next cycle ag_vin=1, alusel=11, rmsel=1, re=0, we=0, modrm=0xC1, de_count=1.
- Opcode 0x01 ModRM 0x05 disp 0x00001000 → re=1, we=1, de_disp=0x00001000.
- mr_stall=1 while enqueuing 5 instructions, DEPTH=4 → de_count=4, de_ready=0, fifth not accepted; release stall → entries drain in order, one per cycle.
- Head valid, reg_dep=1 for 3 cycles → ag_vin=0, head held; reg_dep=0 → ag_vin=1 same cycle.
- Opcode 0x0F → de_illegal=1, all other fields 0, entry ordered between neighbours.
- Queue with 3 entries, flush=1 with fe_v=1 → next cycle de_count=0, ag_vin=0, outputs 0.
